// File: rtl/wheel_mode_pkg.sv
// Shared types and helpers for the per-wheel open/closed-loop duty sequencer.
package wheel_mode_pkg;

  localparam int unsigned DEF_DUTY_W   = 12;
  localparam int unsigned DEF_DUTY_MAX = 2047;
  localparam int unsigned DEAD_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_OL    = 2'd0,
    ST_CL    = 2'd1,
    ST_BLANK = 2'd2,
    ST_CLEAR = 2'd3
  } wheel_state_e;

  // Symmetric clamp so the most negative code never reaches the PWM stage.
  function automatic int sat_duty(input int x, input int lim);
    int r;
    r = x;
    if (x > lim) begin
      r = lim;
    end else if (x < -lim) begin
      r = -lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/wheel_mode_chan.sv
// One wheel: mode FSM (OL/CL/BLANK/CLEAR), dead-time counter, saturation and
// optional slew limiting (enabled by WHEEL_SLEW_LIMIT_EN).
module wheel_mode_chan
  import wheel_mode_pkg::*;
#(
  parameter int unsigned DUTY_W     = DEF_DUTY_W,
  parameter int unsigned DUTY_MAX   = DEF_DUTY_MAX,
  parameter int unsigned DEAD_TICKS = 8
`ifdef WHEEL_SLEW_LIMIT_EN
  , parameter int unsigned SLEW_STEP = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_ol,
  input  logic                     pwm_tick,
  input  logic signed [DUTY_W-1:0] ol_duty,
  input  logic signed [DUTY_W-1:0] cl_duty,
  output logic signed [DUTY_W-1:0] duty_out,
  output logic                     pi_clear,
  output logic                     mode_cl,
  output logic                     busy_nxt_c
);

  wheel_state_e             state_q, state_d;
  logic [DEAD_CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [DUTY_W-1:0] duty_q, duty_d;
  logic                     pi_clear_q, pi_clear_d;
  logic                     mode_cl_q, mode_cl_d;
  logic                     use_cl;
  logic signed [DUTY_W-1:0] sel_sat, track_duty, entry_duty;

  // In CLEAR the source is the one the request selects for the coming mode.
  always_comb begin
    use_cl  = (state_q == ST_CL) || ((state_q == ST_CLEAR) && !req_ol);
    sel_sat = DUTY_W'(sat_duty(use_cl ? int'(cl_duty) : int'(ol_duty), int'(DUTY_MAX)));
  end

`ifdef WHEEL_SLEW_LIMIT_EN
  int slew_diff;

  always_comb begin
    slew_diff  = int'(sel_sat) - int'(duty_q);
    track_duty = duty_q;
    entry_duty = '0;
    if (pwm_tick) begin
      if (slew_diff > int'(SLEW_STEP)) begin
        track_duty = DUTY_W'(int'(duty_q) + int'(SLEW_STEP));
      end else if (slew_diff < -int'(SLEW_STEP)) begin
        track_duty = DUTY_W'(int'(duty_q) - int'(SLEW_STEP));
      end else begin
        track_duty = sel_sat;
      end
    end
  end
`else
  always_comb begin
    track_duty = sel_sat;
    entry_duty = sel_sat;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = '0;
    case (state_q)
      ST_OL: begin
        if (!req_ol) begin
          state_d = ST_BLANK;
          cnt_d   = DEAD_CNT_W'(DEAD_TICKS);
        end else begin
          duty_d = track_duty;
        end
      end
      ST_CL: begin
        if (req_ol) begin
          state_d = ST_BLANK;
          cnt_d   = DEAD_CNT_W'(DEAD_TICKS);
        end else begin
          duty_d = track_duty;
        end
      end
      ST_BLANK: begin
        if (DEAD_TICKS == 0) begin
          state_d = ST_CLEAR;
        end else if (pwm_tick) begin
          cnt_d = cnt_q - DEAD_CNT_W'(1);
          if (cnt_q == DEAD_CNT_W'(1)) begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        state_d = req_ol ? ST_OL : ST_CL;
        duty_d  = entry_duty;
      end
      default: state_d = ST_OL;
    endcase
    // Flags are registered from the next state so they align with state_q.
    pi_clear_d = (state_d == ST_CLEAR);
    mode_cl_d  = (state_d == ST_CL);
    busy_nxt_c = (state_d == ST_BLANK) || (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OL;
      cnt_q      <= '0;
      duty_q     <= '0;
      pi_clear_q <= 1'b0;
      mode_cl_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pi_clear_q <= pi_clear_d;
      mode_cl_q  <= mode_cl_d;
    end
  end

  assign duty_out = duty_q;
  assign pi_clear = pi_clear_q;
  assign mode_cl  = mode_cl_q;

endmodule

// File: rtl/wheel_mode_sequencer.sv
// Per-wheel open-loop / PI duty source sequencer with dead-time blanking and
// integrator clear; optional slew limiting via WHEEL_SLEW_LIMIT_EN.
module wheel_mode_sequencer
  import wheel_mode_pkg::*;
#(
  parameter int unsigned N_WHEEL    = 4,
  parameter int unsigned DUTY_W     = DEF_DUTY_W,
  parameter int unsigned DUTY_MAX   = DEF_DUTY_MAX,
  parameter int unsigned DEAD_TICKS = 8
`ifdef WHEEL_SLEW_LIMIT_EN
  , parameter int unsigned SLEW_STEP = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [4:0]                  is_open_loop,
  input  logic                        pwm_tick,
  input  logic [N_WHEEL*DUTY_W-1:0]   ol_duty,
  input  logic [N_WHEEL*DUTY_W-1:0]   cl_duty,
  output logic [N_WHEEL*DUTY_W-1:0]   duty_out,
  output logic [N_WHEEL-1:0]          pi_clear,
  output logic [N_WHEEL-1:0]          mode_cl,
  output logic                        busy
);

  logic [N_WHEEL-1:0] req_ol_q, req_ol_d;
  logic [N_WHEEL-1:0] chan_busy_c;
  logic               busy_q, busy_d;

  // Bit 4 forces every wheel open-loop.
  always_comb begin
    req_ol_d = is_open_loop[N_WHEEL-1:0] | {N_WHEEL{is_open_loop[4]}};
    busy_d   = |chan_busy_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ol_q <= '1;
      busy_q   <= 1'b0;
    end else begin
      req_ol_q <= req_ol_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar i = 0; i < int'(N_WHEEL); i++) begin : g_chan
    wheel_mode_chan #(
      .DUTY_W     (DUTY_W),
      .DUTY_MAX   (DUTY_MAX),
      .DEAD_TICKS (DEAD_TICKS)
`ifdef WHEEL_SLEW_LIMIT_EN
      , .SLEW_STEP (SLEW_STEP)
`endif
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_ol     (req_ol_q[i]),
      .pwm_tick   (pwm_tick),
      .ol_duty    (ol_duty[i*DUTY_W +: DUTY_W]),
      .cl_duty    (cl_duty[i*DUTY_W +: DUTY_W]),
      .duty_out   (duty_out[i*DUTY_W +: DUTY_W]),
      .pi_clear   (pi_clear[i]),
      .mode_cl    (mode_cl[i]),
      .busy_nxt_c (chan_busy_c[i])
    );
  end

endmodule

// File: tb/tb_wheel_mode_sequencer.sv
// Bench for wheel_mode_sequencer: behavioural per-wheel model checked every
// cycle, plus directed literal expectations; covers WHEEL_SLEW_LIMIT_EN builds.
module tb_wheel_mode_sequencer;

  localparam int NW   = 4;
  localparam int DW   = 12;
  localparam int DMAX = 2047;
  localparam int DEAD = 8;
  localparam int STEP = 16;
`ifdef WHEEL_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [4:0]        is_open_loop = 5'b10000;
  logic              pwm_tick = 1'b0;
  logic [NW*DW-1:0]  ol_duty = '0;
  logic [NW*DW-1:0]  cl_duty = '0;
  logic [NW*DW-1:0]  duty_out;
  logic [NW-1:0]     pi_clear;
  logic [NW-1:0]     mode_cl;
  logic              busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wheel_mode_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .is_open_loop (is_open_loop),
    .pwm_tick     (pwm_tick),
    .ol_duty      (ol_duty),
    .cl_duty      (cl_duty),
    .duty_out     (duty_out),
    .pi_clear     (pi_clear),
    .mode_cl      (mode_cl),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > DMAX) return DMAX;
    if (x < -DMAX) return -DMAX;
    return x;
  endfunction

  function automatic int field(input logic [NW*DW-1:0] v, input int i);
    logic signed [DW-1:0] s;
    s = v[i*DW +: DW];
    return int'(s);
  endfunction

  function automatic int follow(input int cur, input int tgt, input bit tick);
    if (!SLEW) return tgt;
    if (!tick) return cur;
    if (tgt - cur > STEP) return cur + STEP;
    if (cur - tgt > STEP) return cur - STEP;
    return tgt;
  endfunction

  // Model: mode 0=open loop, 1=closed loop; left = remaining dead ticks (-1 idle).
  int m_mode[NW];
  int m_left[NW];
  bit m_clr[NW];
  bit m_req[NW];
  int m_duty[NW];
  bit m_on = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NW; i++) begin
        m_mode[i] = 0; m_left[i] = -1; m_clr[i] = 1'b0; m_req[i] = 1'b1; m_duty[i] = 0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        int t_ol, t_cl;
        bit r;
        r    = m_req[i];
        t_ol = sat(field(ol_duty, i));
        t_cl = sat(field(cl_duty, i));
        if (m_clr[i]) begin
          m_clr[i]  = 1'b0;
          m_mode[i] = r ? 0 : 1;
          m_duty[i] = SLEW ? 0 : (r ? t_ol : t_cl);
        end else if (m_left[i] >= 0) begin
          m_duty[i] = 0;
          if (m_left[i] == 0) begin
            m_left[i] = -1; m_clr[i] = 1'b1;
          end else if (pwm_tick) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_left[i] = -1; m_clr[i] = 1'b1;
            end
          end
        end else if (r != (m_mode[i] == 0)) begin
          m_left[i] = DEAD;
          m_duty[i] = 0;
        end else begin
          m_duty[i] = follow(m_duty[i], (m_mode[i] == 1) ? t_cl : t_ol, pwm_tick);
        end
        m_req[i] = is_open_loop[i] | is_open_loop[4];
      end
    end
  end

  int clr_cnt[NW];

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      logic [NW*DW-1:0] ev;
      logic [NW-1:0]    ec, em;
      logic             eb;
      eb = 1'b0;
      for (int i = 0; i < NW; i++) begin
        ev[i*DW +: DW] = DW'(m_duty[i]);
        ec[i] = m_clr[i];
        em[i] = (m_mode[i] == 1) && (m_left[i] < 0) && !m_clr[i];
        eb    = eb | (m_left[i] >= 0) | m_clr[i];
        if (pi_clear[i] === 1'b1) clr_cnt[i]++;
      end
      chk("model_duty_out", duty_out, ev);
      chk("model_pi_clear", pi_clear, ec);
      chk("model_mode_cl", mode_cl, em);
      chk("model_busy", busy, eb);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pwm_tick = 1'b1;
      step(1);
      pwm_tick = 1'b0;
      step(3);
    end
  endtask

  task automatic set_ol(input int i, input int v);
    ol_duty[i*DW +: DW] = DW'(v);
  endtask

  task automatic set_cl(input int i, input int v);
    cl_duty[i*DW +: DW] = DW'(v);
  endtask

  task automatic chk_duty(input string name, input int i, input int exp);
    logic signed [DW-1:0] s;
    s = duty_out[i*DW +: DW];
    chk(name, s, exp);
  endtask

  int snap[NW];

  task automatic take_snap();
    for (int i = 0; i < NW; i++) snap[i] = clr_cnt[i];
  endtask

  task automatic chk_clr(input string name, input logic [NW-1:0] exp_pulses);
    logic [NW-1:0] got;
    for (int i = 0; i < NW; i++) got[i] = ((clr_cnt[i] - snap[i]) == 1);
    chk(name, got, exp_pulses);
    for (int i = 0; i < NW; i++) chk({name, "_count"}, clr_cnt[i] - snap[i], int'(exp_pulses[i]));
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      set_ol(i, 0);
      set_cl(i, -300);
      clr_cnt[i] = 0;
    end
    set_ol(0, 500);
    #1 reset_n = 1'b0;
    #1 m_on = 1'b1;
    step(3);
    chk("reset_duty", duty_out, '0);
    chk("reset_mode_cl", mode_cl, '0);
    chk("reset_busy", busy, 1'b0);
    reset_n = 1'b1;

    // 1: open-loop after release
    step(1);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk_duty("t1_duty0", 0, 500);
`endif
    chk("t1_mode_cl", mode_cl, 4'b0000);
    chk("t1_busy", busy, 1'b0);

    // 2: all wheels to closed loop
    is_open_loop = 5'b00000;
    step(2);
    chk("t2_busy_enter", busy, 1'b1);
    chk("t2_duty_blank", duty_out, '0);
    take_snap();
    ticks(7);
    chk("t2_busy_t7", busy, 1'b1);
    chk("t2_noclear_t7", pi_clear, 4'b0000);
    ticks(1);
    chk_clr("t2_clear", 4'b1111);
    chk("t2_mode_cl", mode_cl, 4'b1111);
    chk("t2_busy_done", busy, 1'b0);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk("t2_duty", duty_out, {4{12'hED4}});
`endif

    // 3: wheel 0 alone back to open loop
    set_cl(1, 123);
    is_open_loop = 5'b00001;
    step(2);
    chk("t3_mode_blank", mode_cl, 4'b1110);
    chk("t3_busy", busy, 1'b1);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk_duty("t3_duty1", 1, 123);
`endif
    take_snap();
    ticks(8);
    chk_clr("t3_clear", 4'b0001);
    chk("t3_mode_cl", mode_cl, 4'b1110);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk_duty("t3_duty0", 0, 500);
`endif

    // 4: reversal during BLANK
    is_open_loop = 5'b00000;
    step(2);
    take_snap();
    ticks(3);
    is_open_loop = 5'b00001;
    ticks(4);
    chk("t4_busy_t7", busy, 1'b1);
    chk("t4_mode_t7", mode_cl, 4'b1110);
    ticks(1);
    chk_clr("t4_clear", 4'b0001);
    chk("t4_mode_cl", mode_cl, 4'b1110);
    chk("t4_busy", busy, 1'b0);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk_duty("t4_duty0", 0, 500);
`endif

    // 5: saturation, then reset mid-BLANK
    is_open_loop = 5'b10000;
    step(2);
    ticks(8);
    step(2);
    chk("t5_all_ol", mode_cl, 4'b0000);
    set_ol(0, -2048);
    set_ol(1, 2047);
    set_ol(2, -2047);
    step(1);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk_duty("t5_sat_neg", 0, -2047);
    chk_duty("t5_sat_pos", 1, 2047);
    chk_duty("t5_min_legal", 2, -2047);
`endif
    is_open_loop = 5'b00000;
    step(2);
    ticks(2);
    chk("t5_busy_pre", busy, 1'b1);
    take_snap();
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_duty", duty_out, '0);
    chk("t5_rst_clear", pi_clear, 4'b0000);
    chk("t5_rst_busy", busy, 1'b0);
    is_open_loop = 5'b10000;
    step(3);
    reset_n = 1'b1;
    step(1);
    chk_clr("t5_no_clear", 4'b0000);
    chk("t5_mode_cl", mode_cl, 4'b0000);
`ifndef WHEEL_SLEW_LIMIT_EN
    chk_duty("t5_post_duty0", 0, -2047);
`endif

`ifdef WHEEL_SLEW_LIMIT_EN
    // 6: slew ramp 0 -> 1000
    for (int i = 0; i < NW; i++) set_ol(i, 0);
    chk_duty("t6_start", 0, 0);
    set_ol(0, 1000);
    step(2);
    chk_duty("t6_no_tick_hold", 0, 0);
    ticks(1);
    chk_duty("t6_first_step", 0, 16);
    ticks(61);
    chk_duty("t6_tick62", 0, 992);
    step(1);
    chk_duty("t6_hold", 0, 992);
    ticks(1);
    chk_duty("t6_land", 0, 1000);
    ticks(1);
    chk_duty("t6_stable", 0, 1000);
`endif

    m_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
